// File: rtl/mem_controller.sv
// mem_controller: stores a burst of words into local RAM, then hands them one at a time
// to the processing register under command from core_control.
module mem_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              ctrl_clk,
    input  logic              ctrl_reset,
    input  logic [2:0]        ctrl_data_contition,
    input  logic [5:0]        mc_data_length,
    input  logic [DATA_W-1:0] mc_data_in,
    input  logic              mc_data_in_valid,
    output logic              mc_data_in_ready,
    input  logic              procc_done,
    output logic [DATA_W-1:0] mc_reg_data,
    output logic              mc_reg_valid,
    output logic              mc_done,
    output logic              mc_data_done
);
    localparam int PW = ADDR_W + 1;
    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_STORE = 3'b100;
    localparam logic [2:0] C_XFER  = 3'b010;
    localparam logic [2:0] C_PROC  = 3'b001;

    typedef enum logic [1:0] {IDLE, STORE, LOAD, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     len_q, len_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [2:0]        served_q, served_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic              reg_valid_q, reg_valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              wr_en;
    logic              start;

    assign mc_data_in_ready = (state_q == STORE) && (wr_ptr_q < len_q);
    assign wr_en            = mc_data_in_ready && mc_data_in_valid;
    assign mc_data_done     = (ctrl_data_contition == C_PROC) && (rd_ptr_q == len_q) && procc_done;
    assign mc_reg_data      = reg_data_q;
    assign mc_reg_valid     = reg_valid_q;
    assign mc_done          = done_q;

    // A store command restarts from IDLE, or from HOLD unless it is the stale one just served.
    assign start = (ctrl_data_contition == C_STORE) &&
                   ((state_q == IDLE) || ((state_q == HOLD) && (served_q != C_STORE)));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        served_d    = served_q;
        reg_data_d  = reg_data_q;
        reg_valid_d = reg_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: state_d = (ctrl_data_contition == C_XFER) ? LOAD : IDLE;
            STORE: begin
                if (ctrl_data_contition == C_IDLE) begin
                    state_d = IDLE;
                end else if (wr_ptr_q == len_q) begin
                    done_d   = 1'b1;
                    served_d = C_STORE;
                    state_d  = HOLD;
                end
            end
            LOAD: begin
                if (rd_ptr_q < len_q) begin
                    reg_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                end
                reg_valid_d = rd_ptr_q < len_q;
                done_d      = 1'b1;
                served_d    = C_XFER;
                state_d     = HOLD;
            end
            HOLD: begin
                if (ctrl_data_contition != served_q) begin
                    if (ctrl_data_contition == C_XFER) begin
                        state_d = LOAD;
                    end else if (ctrl_data_contition == C_PROC) begin
                        served_d = C_PROC;
                    end else if (ctrl_data_contition == C_IDLE) begin
                        reg_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
        endcase
        if (start) begin
            len_d    = PW'(mc_data_length);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = STORE;
        end
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            served_q    <= '0;
            reg_data_q  <= '0;
            reg_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            served_q    <= served_d;
            reg_data_q  <= reg_data_d;
            reg_valid_q <= reg_valid_d;
            done_q      <= done_d;
        end
    end

    // RAM contents survive reset; only the pointers are cleared.
    always_ff @(posedge ctrl_clk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= mc_data_in;
    end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed vector table, hand sequences for stall/reset/abort,
// and a randomized run checked against a behavioural reference model.
module tb_mem_controller;
    logic       ctrl_clk = 1'b0;
    logic       ctrl_reset = 1'b1;
    logic [2:0] cond;
    logic [5:0] len;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       procc_done;
    logic [7:0] reg_data;
    logic       reg_valid;
    logic       done;
    logic       data_done;

    mem_controller #(.DATA_W(8), .ADDR_W(6)) dut (
        .ctrl_clk(ctrl_clk),
        .ctrl_reset(ctrl_reset),
        .ctrl_data_contition(cond),
        .mc_data_length(len),
        .mc_data_in(din),
        .mc_data_in_valid(din_valid),
        .mc_data_in_ready(din_ready),
        .procc_done(procc_done),
        .mc_reg_data(reg_data),
        .mc_reg_valid(reg_valid),
        .mc_done(done),
        .mc_data_done(data_done)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        int c, l, d, v, p, er, edd, edone, ereg, evalid;
    } vec_t;
    vec_t tbl[25];

    localparam int F_IDLE = 0, F_FILL = 1, F_FETCH = 2, F_PARK = 3;
    int       m_mode, m_len, m_wr, m_rd, m_served;
    logic [7:0] m_mem[64];
    bit       m_ok[64];
    logic [7:0] m_reg;
    bit       m_reg_known, m_valid, m_done, prev_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic vec(input int c, l, d, v, p, er, edd, edone, ereg, evalid);
        @(negedge ctrl_clk);
        cond = 3'(c); len = 6'(l); din = 8'(d); din_valid = 1'(v); procc_done = 1'(p);
        #2;
        chk("ready", 32'(din_ready), er);
        chk("data_done", 32'(data_done), edd);
        @(posedge ctrl_clk);
        #1;
        chk("done", 32'(done), edone);
        chk("reg_data", 32'(reg_data), ereg);
        chk("reg_valid", 32'(reg_valid), evalid);
    endtask

    task automatic do_reset();
        @(negedge ctrl_clk);
        cond = 3'b000; din_valid = 1'b0; procc_done = 1'b0;
        #2 ctrl_reset = 1'b1;
        #1;
        chk("rst_ready", 32'(din_ready), 0);
        chk("rst_reg_data", 32'(reg_data), 0);
        chk("rst_reg_valid", 32'(reg_valid), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        ctrl_reset = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = F_IDLE; m_len = 0; m_wr = 0; m_rd = 0; m_served = 0;
        m_reg = 8'h00; m_reg_known = 1'b1; m_valid = 1'b0; m_done = 1'b0; prev_done = 1'b0;
    endtask

    task automatic model_start(input int l);
        m_len = l; m_wr = 0; m_rd = 0; m_mode = F_FILL;
    endtask

    task automatic model_edge(input int c, l, d, v);
        m_done = 1'b0;
        case (m_mode)
            F_IDLE: begin
                if (c == 4) model_start(l);
                else if (c == 2) m_mode = F_FETCH;
            end
            F_FILL: begin
                bit acc;
                acc = (m_wr < m_len) && (v != 0);
                if (c == 0) m_mode = F_IDLE;
                else if (m_wr == m_len) begin m_done = 1'b1; m_served = 4; m_mode = F_PARK; end
                if (acc) begin m_mem[m_wr] = 8'(d); m_ok[m_wr] = 1'b1; m_wr++; end
            end
            F_FETCH: begin
                if (m_rd < m_len) begin
                    m_reg = m_mem[m_rd]; m_reg_known = m_ok[m_rd]; m_valid = 1'b1; m_rd++;
                end else m_valid = 1'b0;
                m_done = 1'b1; m_served = 2; m_mode = F_PARK;
            end
            default: begin
                if (c != m_served) begin
                    if (c == 2) m_mode = F_FETCH;
                    else if (c == 1) m_served = 1;
                    else if (c == 4) model_start(l);
                    else if (c == 0) begin m_valid = 1'b0; m_mode = F_IDLE; end
                end
            end
        endcase
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            int r, l, d, v, p;
            logic [2:0] c;
            if (i % 600 == 599) begin do_reset(); model_reset(); end
            r = int'($urandom_range(0, 9));
            if (r < 5) c = cond;
            else if (r < 9) begin
                case ($urandom_range(0, 3))
                    0: c = 3'b000;
                    1: c = 3'b001;
                    2: c = 3'b010;
                    default: c = 3'b100;
                endcase
            end else c = 3'($urandom_range(0, 7));
            l = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 255));
            v = int'($urandom_range(0, 1));
            p = int'($urandom_range(0, 1));
            @(negedge ctrl_clk);
            cond = c; len = 6'(l); din = 8'(d); din_valid = 1'(v); procc_done = 1'(p);
            #2;
            chk("r_ready", 32'(din_ready), 32'(m_mode == F_FILL && m_wr < m_len));
            chk("r_data_done", 32'(data_done), 32'(c == 3'b001 && m_rd == m_len && p != 0));
            @(posedge ctrl_clk);
            model_edge(int'(c), l, d, v);
            #1;
            chk("r_done", 32'(done), 32'(m_done));
            chk("r_reg_valid", 32'(reg_valid), 32'(m_valid));
            if (m_reg_known) chk("r_reg_data", 32'(reg_data), 32'(m_reg));
            chk("r_done_twice", 32'(done && prev_done), 0);
            prev_done = done;
        end
    endtask

    initial begin
        cond = 3'b000; len = 6'd0; din = 8'h00; din_valid = 1'b0; procc_done = 1'b0;
        repeat (3) @(posedge ctrl_clk);
        #1;
        chk("init_ready", 32'(din_ready), 0);
        chk("init_reg_data", 32'(reg_data), 0);
        chk("init_reg_valid", 32'(reg_valid), 0);
        chk("init_done", 32'(done), 0);
        @(negedge ctrl_clk);
        ctrl_reset = 1'b0;

        // c, l, d, v, p | ready, data_done (this cycle) | done, reg_data, reg_valid (after edge)
        tbl = '{
            '{'b100, 3, 'h00, 0, 0, 0, 0, 0, 'h00, 0},
            '{'b100, 3, 'hA1, 1, 0, 1, 0, 0, 'h00, 0},
            '{'b100, 3, 'hB2, 1, 0, 1, 0, 0, 'h00, 0},
            '{'b100, 3, 'hC3, 1, 0, 1, 0, 0, 'h00, 0},
            '{'b100, 3, 'h00, 0, 0, 0, 0, 1, 'h00, 0},
            '{'b100, 3, 'hFF, 1, 0, 0, 0, 0, 'h00, 0},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 0, 'h00, 0},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 1, 'hA1, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 0, 'hA1, 1},
            '{'b001, 3, 'h00, 0, 0, 0, 0, 0, 'hA1, 1},
            '{'b001, 3, 'h00, 0, 1, 0, 0, 0, 'hA1, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 0, 'hA1, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 1, 'hB2, 1},
            '{'b011, 3, 'h00, 0, 0, 0, 0, 0, 'hB2, 1},
            '{'b001, 3, 'h00, 0, 1, 0, 0, 0, 'hB2, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 0, 'hB2, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 1, 'hC3, 1},
            '{'b001, 3, 'h00, 0, 0, 0, 0, 0, 'hC3, 1},
            '{'b001, 3, 'h00, 0, 1, 0, 1, 0, 'hC3, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 0, 'hC3, 1},
            '{'b010, 3, 'h00, 0, 0, 0, 0, 1, 'hC3, 0},
            '{'b000, 3, 'h00, 0, 0, 0, 0, 0, 'hC3, 0},
            '{'b100, 0, 'h00, 0, 0, 0, 0, 0, 'hC3, 0},
            '{'b100, 0, 'h00, 0, 0, 0, 0, 1, 'hC3, 0},
            '{'b000, 0, 'h00, 0, 0, 0, 0, 0, 'hC3, 0}
        };
        foreach (tbl[i])
            vec(tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].v, tbl[i].p,
                tbl[i].er, tbl[i].edd, tbl[i].edone, tbl[i].ereg, tbl[i].evalid);

        // stalled burst: ready holds through gaps, mc_done only after the third word
        vec('b100, 3, 'h00, 0, 0, 0, 0, 0, 'hC3, 0);
        vec('b100, 3, 'hA1, 1, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'h00, 0, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'hB2, 1, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'h00, 0, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'h00, 0, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'hC3, 1, 0, 1, 0, 0, 'hC3, 0);
        vec('b100, 3, 'h00, 0, 0, 0, 0, 1, 'hC3, 0);
        vec('b010, 3, 'h00, 0, 0, 0, 0, 0, 'hC3, 0);
        vec('b010, 3, 'h00, 0, 0, 0, 0, 1, 'hA1, 1);

        // restart from HOLD, reset mid-burst, then a fresh burst lands at address 0
        vec('b100, 5, 'h00, 0, 0, 0, 0, 0, 'hA1, 1);
        vec('b100, 5, 'h11, 1, 0, 1, 0, 0, 'hA1, 1);
        vec('b100, 5, 'h22, 1, 0, 1, 0, 0, 'hA1, 1);
        do_reset();
        vec('b100, 2, 'h00, 0, 0, 0, 0, 0, 'h00, 0);
        vec('b100, 2, 'hD4, 1, 0, 1, 0, 0, 'h00, 0);
        vec('b100, 2, 'hE5, 1, 0, 1, 0, 0, 'h00, 0);
        vec('b100, 2, 'h00, 0, 0, 0, 0, 1, 'h00, 0);
        vec('b010, 2, 'h00, 0, 0, 0, 0, 0, 'h00, 0);
        vec('b010, 2, 'h00, 0, 0, 0, 0, 1, 'hD4, 1);
        vec('b001, 2, 'h00, 0, 1, 0, 0, 0, 'hD4, 1);
        vec('b010, 2, 'h00, 0, 0, 0, 0, 0, 'hD4, 1);
        vec('b010, 2, 'h00, 0, 0, 0, 0, 1, 'hE5, 1);
        vec('b001, 2, 'h00, 0, 1, 0, 1, 0, 'hE5, 1);

        // abort mid-store: ready drops a cycle later, no mc_done, partial word kept in RAM
        vec('b000, 2, 'h00, 0, 0, 0, 0, 0, 'hE5, 0);
        vec('b100, 4, 'h00, 0, 0, 0, 0, 0, 'hE5, 0);
        vec('b100, 4, 'h33, 1, 0, 1, 0, 0, 'hE5, 0);
        vec('b000, 4, 'h00, 0, 0, 1, 0, 0, 'hE5, 0);
        vec('b000, 4, 'h00, 0, 0, 0, 0, 0, 'hE5, 0);
        vec('b010, 4, 'h00, 0, 0, 0, 0, 0, 'hE5, 0);
        vec('b010, 4, 'h00, 0, 0, 0, 0, 1, 'h33, 1);

        do_reset();
        model_reset();
        foreach (m_ok[k]) m_ok[k] = 1'b0;
        rand_run(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
